// File: rtl/vector_checker_if.sv
// Handshake/bus bundle between the vector loader, the checker and the DUT.
// master = loader/DUT side, slave = vector_checker.
interface vector_checker_if #(
  parameter int NIN  = 3,
  parameter int NOUT = 1,
  parameter int AW   = 4,
  parameter int CW   = 16
);
  logic                    start;
  logic                    load_we;
  logic [AW-1:0]           load_addr;
  logic [NIN+NOUT:0]       load_data;
  logic [NIN-1:0]          dut_in;
  logic [NOUT-1:0]         dut_out;
  logic                    busy;
  logic                    done;
  logic [CW-1:0]           vectornum;
  logic [CW-1:0]           errors;
  logic [AW-1:0]           first_err;
  logic [NOUT-1:0]         first_got;

  modport master (
    output start, load_we, load_addr, load_data, dut_out,
    input  dut_in, busy, done, vectornum, errors,
    input  first_err, first_got
  );

  modport slave (
    input  start, load_we, load_addr, load_data, dut_out,
    output dut_in, busy, done, vectornum, errors,
    output first_err, first_got
  );
endinterface

// File: rtl/vector_checker.sv
// Vector-memory self-test sequencer: applies stored stimulus, checks DUT.
// Define VECCHK_ERRLOG_EN to build the first-failure log registers.
module vector_checker #(
  parameter int NIN   = 3,
  parameter int NOUT  = 1,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  vector_checker_if.slave bus
);
  localparam int W = 1 + NIN + NOUT;

  typedef enum logic [1:0] {
    IDLE, APPLY, CHECK, DONE
  } state_t;

  if (CW < AW + 1) begin : g_cw_chk
    $error("vector_checker: CW must be >= AW+1");
  end
  if (DEPTH != (1 << AW)) begin : g_depth_chk
    $error("vector_checker: DEPTH must be 2**AW");
  end

  state_t            state_q;
  logic [W-1:0]      mem_q [DEPTH];
  logic [AW-1:0]     ptr_q;
  logic [NIN-1:0]    din_q;
  logic [NOUT-1:0]   exp_q;
  logic [CW-1:0]     vn_q;
  logic [CW-1:0]     err_q;
  logic [CW-1:0]     err_d;
  logic [AW-1:0]     ptr_d;
  logic              idle_w;
  logic              last_w;
  logic              miss_w;

  assign idle_w = (state_q == IDLE) || (state_q == DONE);
  assign ptr_d  = ptr_q + AW'(1);
  // the ptr==DEPTH-1 term keeps ptr_d's wrap from ever being followed
  assign last_w = (ptr_q == AW'(DEPTH - 1)) || !mem_q[ptr_d][W-1];
  assign miss_w = (bus.dut_out != exp_q);
  assign err_d  = (miss_w && (err_q != '1)) ? err_q + CW'(1) : err_q;

  always_ff @(posedge clk) begin
    if (bus.load_we && idle_w)
      mem_q[bus.load_addr] <= bus.load_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      din_q   <= '0;
      exp_q   <= '0;
      vn_q    <= '0;
      err_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            ptr_q   <= '0;
            vn_q    <= '0;
            err_q   <= '0;
            state_q <= mem_q[0][W-1] ? APPLY : DONE;
          end
        end
        APPLY: begin
          din_q   <= mem_q[ptr_q][NOUT +: NIN];
          exp_q   <= mem_q[ptr_q][NOUT-1:0];
          state_q <= CHECK;
        end
        CHECK: begin
          vn_q  <= vn_q + CW'(1);
          err_q <= err_d;
          if (last_w) begin
            state_q <= DONE;
          end else begin
            ptr_q   <= ptr_d;
            state_q <= APPLY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VECCHK_ERRLOG_EN
  logic [AW-1:0]   ferr_q;
  logic [NOUT-1:0] fgot_q;

  // err_q is still zero only on the first mismatch of a run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ferr_q <= '0;
      fgot_q <= '0;
    end else if (idle_w && bus.start) begin
      ferr_q <= '0;
      fgot_q <= '0;
    end else if ((state_q == CHECK) && miss_w && (err_q == '0)) begin
      ferr_q <= ptr_q;
      fgot_q <= bus.dut_out;
    end
  end

  assign bus.first_err = ferr_q;
  assign bus.first_got = fgot_q;
`else
  assign bus.first_err = '0;
  assign bus.first_got = '0;
`endif

  assign bus.dut_in    = din_q;
  assign bus.busy      = (state_q == APPLY) || (state_q == CHECK);
  assign bus.done      = (state_q == DONE);
  assign bus.vectornum = vn_q;
  assign bus.errors    = err_q;
endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker; run outcomes go through a scoreboard.
// Reference DUT: y = ~b&~c | a&~b with {a,b,c} = dut_in.
module tb_vector_checker;
  localparam int NIN   = 3;
  localparam int NOUT  = 1;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 16;

  typedef struct {
    int lat;
    int vn;
    int er;
    int fe;
    int fg;
    int din;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;
  int   t0;
  exp_t sb[$];

  vector_checker_if #(
    .NIN(NIN), .NOUT(NOUT), .AW(AW), .CW(CW)
  ) vif ();

  vector_checker #(
    .NIN(NIN), .NOUT(NOUT), .DEPTH(DEPTH),
    .AW(AW), .CW(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  function automatic logic yref(input logic [2:0] v);
    return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
  endfunction

  assign vif.dut_out = yref(vif.dut_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic v,
                    input logic [2:0] in, input logic e);
    @(negedge clk);
    vif.load_we   = 1'b1;
    vif.load_addr = AW'(a);
    vif.load_data = {v, in, e};
    @(negedge clk);
    vif.load_we   = 1'b0;
  endtask

  task automatic start_run(input exp_t e);
    @(negedge clk);
    vif.start = 1'b1;
    t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    vif.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   to;
    e  = sb.pop_front();
    to = 0;
    while (!vif.done && to < 200) begin
      @(negedge clk);
      to++;
    end
    chk({tag, "_done"}, 32'(vif.done), 1);
    chk({tag, "_lat"}, cyc - t0, e.lat);
    chk({tag, "_vn"}, 32'(vif.vectornum), e.vn);
    chk({tag, "_err"}, 32'(vif.errors), e.er);
    chk({tag, "_ferr"}, 32'(vif.first_err), e.fe);
    chk({tag, "_fgot"}, 32'(vif.first_got), e.fg);
    chk({tag, "_din"}, 32'(vif.dut_in), e.din);
    chk({tag, "_busy"}, 32'(vif.busy), 0);
  endtask

  initial begin
    exp_t e;
    int   fe2;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    vif.start     = 1'b0;
    vif.load_we   = 1'b0;
    vif.load_addr = '0;
    vif.load_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(vif.busy), 0);
    chk("rst_done", 32'(vif.done), 0);
    chk("rst_vn", 32'(vif.vectornum), 0);
    chk("rst_err", 32'(vif.errors), 0);
    chk("rst_din", 32'(vif.dut_in), 0);
    chk("rst_ferr", 32'(vif.first_err), 0);
    reset = 1'b0;

    // scenario 1: full truth table
    for (int i = 0; i < 8; i++)
      wr(i, 1'b1, 3'(i), yref(3'(i)));
    wr(8, 1'b0, 3'd0, 1'b0);
    e = '{lat: 17, vn: 8, er: 0, fe: 0, fg: 0, din: 7};
    start_run(e);
    chk("s1_busy", 32'(vif.busy), 1);
    wait_done("s1");

    // scenario 2: entry 3 expectation inverted
`ifdef VECCHK_ERRLOG_EN
    fe2 = 3;
`else
    fe2 = 0;
`endif
    wr(3, 1'b1, 3'd3, ~yref(3'd3));
    e = '{lat: 17, vn: 8, er: 1, fe: fe2, fg: 0, din: 7};
    start_run(e);
    wait_done("s2");
    wr(3, 1'b1, 3'd3, yref(3'd3));

    // scenario 3: empty memory
    wr(0, 1'b0, 3'd0, yref(3'd0));
    e = '{lat: 1, vn: 0, er: 0, fe: 0, fg: 0, din: 7};
    start_run(e);
    wait_done("s3");
    wr(0, 1'b1, 3'd0, yref(3'd0));

    // scenario 4: every entry valid, hard stop at DEPTH-1
    for (int i = 8; i < DEPTH; i++)
      wr(i, 1'b1, 3'(i % 8), yref(3'(i % 8)));
    e = '{lat: 33, vn: 16, er: 0, fe: 0, fg: 0, din: 7};
    start_run(e);
    wait_done("s4");
    repeat (6) @(negedge clk);
    chk("s4_hold_vn", 32'(vif.vectornum), 16);
    chk("s4_hold_done", 32'(vif.done), 1);
    chk("s4_hold_busy", 32'(vif.busy), 0);
    wr(8, 1'b0, 3'd0, 1'b0);

    // scenario 5: reset mid-run
    @(negedge clk);
    vif.start = 1'b1;
    @(negedge clk);
    vif.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("s5_midbusy", 32'(vif.busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("s5_busy", 32'(vif.busy), 0);
    chk("s5_done", 32'(vif.done), 0);
    chk("s5_vn", 32'(vif.vectornum), 0);
    chk("s5_err", 32'(vif.errors), 0);
    chk("s5_din", 32'(vif.dut_in), 0);
    @(negedge clk);
    reset = 1'b0;
    e = '{lat: 17, vn: 8, er: 0, fe: 0, fg: 0, din: 7};
    start_run(e);
    wait_done("s5r");

    // scenario 6: write and restart attempts while busy
    e = '{lat: 17, vn: 8, er: 0, fe: 0, fg: 0, din: 7};
    start_run(e);
    @(negedge clk);
    vif.load_we   = 1'b1;
    vif.load_addr = AW'(2);
    vif.load_data = {1'b1, 3'd2, ~yref(3'd2)};
    vif.start     = 1'b1;
    @(negedge clk);
    vif.load_we   = 1'b0;
    vif.start     = 1'b0;
    repeat (5) @(negedge clk);
    vif.start = 1'b1;
    @(negedge clk);
    vif.start = 1'b0;
    wait_done("s6");
    e = '{lat: 17, vn: 8, er: 0, fe: 0, fg: 0, din: 7};
    start_run(e);
    wait_done("s6b");

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
